// File: rtl/lane_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lane_op_sequencer
//  Description : Per-lane operand selector that feeds an accumulator register.
//                The accumulator applies one of six bitwise operations per
//                accepted step, either auto-sequenced or forced by op_in.
//                The result is held in a 1-deep valid/ready output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_op_sequencer #(
    parameter  int LANES  = 2,
    parameter  int LANE_W = 8,
    localparam int W      = LANES * LANE_W
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*LANES-1:0] sel,
    input  logic [W-1:0]       b,
    input  logic [W-1:0]       c,
    input  logic               mode,
    input  logic [2:0]         op_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out,
    output logic [2:0]         step
);

    localparam int       HALF        = LANE_W / 2;

    localparam logic [2:0] OP_LOAD     = 3'd0;
    localparam logic [2:0] OP_SHIFT    = 3'd1;
    localparam logic [2:0] OP_MERGE    = 3'd2;
    localparam logic [2:0] OP_LANE_REV = 3'd3;
    localparam logic [2:0] OP_NIB_REV  = 3'd4;
    localparam logic [2:0] OP_PARITY   = 3'd5;
    localparam logic [2:0] STEP_LAST   = 3'd5;

    logic [W-1:0] out_q, out_d;
    logic [2:0]   step_q, step_d;
    logic         out_valid_q, out_valid_d;

    logic [W-1:0] w_x;
    logic [W-1:0] w_shift;
    logic [W-1:0] w_lane_rev;
    logic [W-1:0] w_nib_rev;
    logic [W-1:0] w_parity;
    logic [2:0]   w_op;
    logic         w_fire;

    // Per-lane operand selection and the lane-wise rearrangements of out.
    genvar l;
    generate
        for (l = 0; l < LANES; l = l + 1) begin : g_lane
            logic [1:0]        w_lsel;
            logic [LANE_W-1:0] w_lb;
            logic [LANE_W-1:0] w_lc;
            assign w_lsel = sel[2*l +: 2];
            assign w_lb   = b[l*LANE_W +: LANE_W];
            assign w_lc   = c[l*LANE_W +: LANE_W];
            assign w_x[l*LANE_W +: LANE_W] =
                (w_lsel == 2'd0) ? w_lb :
                (w_lsel == 2'd1) ? w_lc :
                (w_lsel == 2'd2) ? (w_lb & w_lc) :
                                   (w_lb ^ w_lc);
            assign w_lane_rev[l*LANE_W +: LANE_W] = out_q[(LANES-1-l)*LANE_W +: LANE_W];
            assign w_nib_rev[l*LANE_W +: LANE_W]  = {out_q[l*LANE_W +: HALF],
                                                     out_q[l*LANE_W+HALF +: HALF]};
        end
    endgenerate

    // A single-lane word has nothing to shift up, so SHIFT degenerates to LOAD.
    generate
        if (LANES > 1) begin : g_shift_multi
            assign w_shift = {out_q[W-LANE_W-1:0], w_x[LANE_W-1:0]};
        end else begin : g_shift_single
            assign w_shift = w_x;
        end
    endgenerate

    assign w_parity  = {{(W-1){1'b0}}, ^out_q};
    assign w_op      = mode ? op_in : step_q;
    assign in_ready  = !out_valid_q || out_ready;
    assign w_fire    = in_valid && in_ready;

    assign out       = out_q;
    assign step      = step_q;
    assign out_valid = out_valid_q;

    // Next-state: accumulator op, step counter advance and output-stage valid.
    always_comb begin
        out_d       = out_q;
        step_d      = step_q;
        out_valid_d = out_valid_q;
        if (w_fire) begin
            case (w_op)
                OP_LOAD:     out_d = w_x;
                OP_SHIFT:    out_d = w_shift;
                OP_MERGE:    out_d = out_q ^ w_x;
                OP_LANE_REV: out_d = w_lane_rev;
                OP_NIB_REV:  out_d = w_nib_rev;
                OP_PARITY:   out_d = w_parity;
                default:     out_d = out_q;
            endcase
            if (!mode) begin
                step_d = (step_q == STEP_LAST) ? 3'd0 : step_q + 3'd1;
            end
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            out_q       <= '0;
            step_q      <= 3'd0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            step_q      <= step_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lane_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lane_op_sequencer
//  Description : Directed, table-driven bench for lane_op_sequencer, with a
//                second single-lane instance for the degenerate SHIFT case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_op_sequencer;

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [3:0]  sel;
        logic        mode;
        logic [2:0]  op;
        logic        ordy;
        logic [15:0] e_out;
        logic [2:0]  e_step;
        logic        e_valid;
    } vec_t;

    logic        clk;
    logic        nReset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  sel;
    logic [15:0] b;
    logic [15:0] c;
    logic        mode;
    logic [2:0]  op_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic [2:0]  step;

    logic        nReset1;
    logic        in_valid1;
    logic        in_ready1;
    logic [1:0]  sel1;
    logic [3:0]  b1;
    logic [3:0]  c1;
    logic        out_valid1;
    logic [3:0]  out1;
    logic [2:0]  step1;

    int errors;
    int checks;
    vec_t vecs[$];

    lane_op_sequencer #(.LANES(2), .LANE_W(8)) dut (
        .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .b(b), .c(c), .mode(mode), .op_in(op_in),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .step(step)
    );

    lane_op_sequencer #(.LANES(1), .LANE_W(4)) dut1 (
        .clk(clk), .nReset(nReset1), .in_valid(in_valid1), .in_ready(in_ready1),
        .sel(sel1), .b(b1), .c(c1), .mode(1'b0), .op_in(3'd0),
        .out_valid(out_valid1), .out_ready(1'b1), .out(out1), .step(step1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rn, input logic iv, input logic [3:0] s,
                       input logic md, input logic [2:0] op, input logic ordy,
                       input logic [15:0] eo, input logic [2:0] es, input logic ev);
        vec_t v;
        v.rst_n = rn; v.iv = iv; v.sel = s; v.mode = md; v.op = op; v.ordy = ordy;
        v.e_out = eo; v.e_step = es; v.e_valid = ev;
        vecs.push_back(v);
    endtask

    task automatic run1(input logic rn, input logic [3:0] bv,
                        input logic [3:0] eo, input logic [2:0] es, input string name);
        nReset1 = rn; b1 = bv;
        @(posedge clk); #1;
        chk({name, " out1"}, {12'h0, out1}, {12'h0, eo});
        chk({name, " step1"}, {13'h0, step1}, {13'h0, es});
    endtask

    initial begin
        errors = 0; checks = 0;
        nReset = 1'b0; in_valid = 1'b0; sel = 4'b0100; b = 16'h1234; c = 16'h00FF;
        mode = 1'b0; op_in = 3'd0; out_ready = 1'b1;
        nReset1 = 1'b0; in_valid1 = 1'b0; sel1 = 2'd0; b1 = 4'h0; c1 = 4'h0;

        // Auto-sequence through all six ops and wrap.
        add(0,1,4'h4,0,0,1, 16'h0000,0,0);
        add(1,1,4'h4,0,0,1, 16'h0034,1,1);
        add(1,1,4'h4,0,0,1, 16'h3434,2,1);
        add(1,1,4'h4,0,0,1, 16'h3400,3,1);
        add(1,1,4'h4,0,0,1, 16'h0034,4,1);
        add(1,1,4'h4,0,0,1, 16'h0043,5,1);
        add(1,1,4'h4,0,0,1, 16'h0001,0,1);
        add(1,1,4'h4,0,0,1, 16'h0034,1,1);
        // Backpressure after LOAD, then fixed-mode parity and step preservation.
        add(0,1,4'h4,0,0,1, 16'h0000,0,0);
        add(1,1,4'h4,0,0,1, 16'h0034,1,1);
        add(1,1,4'h4,0,0,0, 16'h0034,1,1);
        add(1,1,4'h4,0,0,0, 16'h0034,1,1);
        add(1,1,4'h4,0,0,0, 16'h0034,1,1);
        add(1,1,4'h4,0,0,1, 16'h3434,2,1);
        add(1,1,4'h4,0,0,1, 16'h3400,3,1);
        add(1,1,4'h4,0,0,1, 16'h0034,4,1);
        add(1,1,4'h4,0,0,1, 16'h0043,5,1);
        add(1,1,4'h4,1,5,1, 16'h0001,5,1);
        add(1,1,4'h4,1,5,1, 16'h0001,5,1);
        add(1,1,4'h4,0,0,1, 16'h0001,0,1);
        add(1,1,4'h4,0,0,1, 16'h0034,1,1);
        // Reset mid-sequence with a pending fire.
        add(1,1,4'h4,0,0,1, 16'h3434,2,1);
        add(1,1,4'h4,0,0,1, 16'h3400,3,1);
        add(0,1,4'h4,0,0,1, 16'h0000,0,0);
        // Mixed lane selects, hold op, then drain.
        add(1,1,4'hE,0,0,1, 16'h1234,1,1);
        add(1,1,4'hE,1,7,1, 16'h1234,1,1);
        add(1,0,4'hE,0,0,1, 16'h1234,1,0);
        add(1,0,4'hE,0,0,0, 16'h1234,1,0);

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            nReset = vecs[i].rst_n; in_valid = vecs[i].iv; sel = vecs[i].sel;
            mode = vecs[i].mode; op_in = vecs[i].op; out_ready = vecs[i].ordy;
            @(posedge clk); #1;
            chk($sformatf("v%0d out", i), out, vecs[i].e_out);
            chk($sformatf("v%0d step", i), {13'h0, step}, {13'h0, vecs[i].e_step});
            chk($sformatf("v%0d out_valid", i), {15'h0, out_valid}, {15'h0, vecs[i].e_valid});
            chk($sformatf("v%0d in_ready", i), {15'h0, in_ready},
                {15'h0, (!vecs[i].e_valid || vecs[i].ordy)});
        end

        // A reset pulse that never spans a rising edge must be ignored.
        in_valid = 1'b0; out_ready = 1'b1;
        nReset = 1'b0; #3; nReset = 1'b1;
        @(posedge clk); #1;
        chk("glitch out", out, 16'h1234);
        chk("glitch step", {13'h0, step}, 16'h0001);

        // Backpressured load must still be held by in_valid with out_ready low.
        in_valid = 1'b1; sel = 4'h4; mode = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("bp fire out", out, 16'h3434);
        chk("bp fire step", {13'h0, step}, 16'h0002);
        @(posedge clk); #1;
        chk("bp hold out", out, 16'h3434);
        chk("bp hold in_ready", {15'h0, in_ready}, 16'h0000);
        in_valid = 1'b0; out_ready = 1'b1;

        // Single-lane instance: SHIFT reduces to LOAD, LANE_REV is identity.
        in_valid1 = 1'b1;
        run1(0, 4'hA, 4'h0, 3'd0, "L1 reset");
        run1(1, 4'hA, 4'hA, 3'd1, "L1 load");
        run1(1, 4'h5, 4'h5, 3'd2, "L1 shift");
        run1(1, 4'h6, 4'h3, 3'd3, "L1 merge");
        run1(1, 4'h6, 4'h3, 3'd4, "L1 lane_rev");
        run1(1, 4'h6, 4'hC, 3'd5, "L1 nib_rev");
        run1(1, 4'h6, 4'h0, 3'd0, "L1 parity");
        chk("L1 out_valid", {15'h0, out_valid1}, 16'h0001);
        in_valid1 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
